// File: rtl/rl_ram_1r1w_ext.sv
// -----------------------------------------------------------------------------
// rl_ram_1r1w_ext
//
// Parametrised 1R1W RAM with byte-enabled writes, self-clearing initialisation
// after reset and a read-enable / valid read interface. After every reset the
// whole array is written with INIT_VALUE, one address per cycle, before the
// block raises ready. The array itself stays a plain inferrable memory; the
// clear FSM, read pipeline and optional bypass are ordinary logic around it.
//
// Optional feature macro: RL_RAM_1R1W_BYPASS_EN
//   defined   - a read and a write to the same address on the same edge
//               return the byte-merged (new) data.
//   undefined - the same case returns the old contents (read before write);
//               no address comparator or merge mux is built.
//
// Parameters
//   ABITS      address width, depth = 2**ABITS
//   DBITS      data width (>= 1)
//   INIT_VALUE value written to every location during the clear
//   OUTREG     0: read latency 1, 1: extra output register, read latency 2
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   ready      high when reads/writes are accepted (clear finished)
//   waddr      write address
//   din        write data
//   we         write enable
//   be         byte enables; the top bit covers the partial top byte
//   raddr      read address
//   re         read enable
//   dout       read data, held between completed reads
//   dout_valid one-cycle strobe marking a completed read
//
// Handshake: requests are sampled on a rising edge only while ready=1; there
// is no back-pressure. A read sampled at edge n completes at edge
// n+1+OUTREG, where dout_valid pulses for exactly one cycle.
// -----------------------------------------------------------------------------
module rl_ram_1r1w_ext #(
    parameter int               ABITS      = 10,
    parameter int               DBITS      = 32,
    parameter logic [DBITS-1:0] INIT_VALUE = '0,
    parameter int               OUTREG     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic [ABITS-1:0]         waddr,
    input  logic [DBITS-1:0]         din,
    input  logic                     we,
    input  logic [(DBITS+7)/8-1:0]   be,
    input  logic [ABITS-1:0]         raddr,
    input  logic                     re,
    output logic [DBITS-1:0]         dout,
    output logic                     dout_valid
);

    localparam int DEPTH = 2 ** ABITS;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // One bit wider than the address so the counter reaches DEPTH after the
    // last clear write instead of wrapping; its top bit marks "clear done".
    logic [ABITS:0]   cnt;
    logic [ABITS:0]   cnt_nxt;

    logic [DBITS-1:0] mem [DEPTH];

    logic [DBITS-1:0] bit_mask;
    logic             mem_we;
    logic [ABITS-1:0] mem_waddr;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_wmask;
    logic             rd_fire;
    logic [DBITS-1:0] rd_word;

    logic             s1_valid;
    logic [DBITS-1:0] s1_data;
    logic             last_valid;
    logic [DBITS-1:0] last_data;

    assign ready = (state == RUN);

    // Expand byte enables into a per-bit mask; bit b belongs to byte b/8, so
    // the top enable naturally covers a partial top byte.
    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < DBITS; b++) begin
            bit_mask[b] = be[b/8];
        end
    end

    // ------------------------------------------------------------------
    // Clear / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = din;
        mem_wmask = bit_mask;
        rd_fire   = 1'b0;
        case (state)
            CLEAR: begin
                mem_waddr = cnt[ABITS-1:0];
                mem_wdata = INIT_VALUE;
                mem_wmask = '1;
                if (cnt[ABITS]) begin
                    // Every address has been written; start serving.
                    state_nxt = RUN;
                end else begin
                    mem_we  = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                mem_we  = we;
                rd_fire = re;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory array: no reset on the contents, the reset edge leaves it alone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int b = 0; b < DBITS; b++) begin
                if (mem_wmask[b]) begin
                    mem[mem_waddr][b] <= mem_wdata[b];
                end
            end
        end
    end

    // Read word. Without the bypass the non-blocking array update makes a
    // same-edge read see the old contents.
    always_comb begin
        rd_word = mem[raddr];
`ifdef RL_RAM_1R1W_BYPASS_EN
        if (we && (waddr == raddr)) begin
            rd_word = (mem[raddr] & ~bit_mask) | (din & bit_mask);
        end
`endif
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 captures the word, optional stage 2, then the
    // output register that holds dout between completed reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            s1_data <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_fire;
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic             s2_valid;
            logic [DBITS-1:0] s2_data;

            always_ff @(posedge clk) begin
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                end
            end

            assign last_valid = s2_valid;
            assign last_data  = s2_data;
        end else begin : g_no_outreg
            assign last_valid = s1_valid;
            assign last_data  = s1_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            dout_valid <= last_valid;
            if (last_valid) begin
                dout <= last_data;
            end
        end
    end

endmodule
